// File: rtl/cube_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cube_layer_scheduler
// Description : Double-buffered 8x8x8 LED cube layer scanner. The front bank
//               is scanned one layer at a time (blank gap, then dwell), while
//               the host fills the back bank. A swap request presents the back
//               bank at the next frame boundary (or immediately when idle).
//               Optional global PWM dimming: define CUBE_PWM_EN.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               enable          - run the scan while high
//               wr_en/wr_addr/wr_data - back-bank byte write (addr=layer*8+row)
//               swap_req        - request to present the back bank
//               brightness      - global duty, used only with CUBE_PWM_EN
//               swap_ack        - 1-cycle pulse in the cycle the swap happens
//               layer_en        - one-hot layer drive, zero when dark
//               col_data        - 64 column bits of the lit layer (row r at 8r)
//               frame_tick      - 1-cycle pulse in the last layer-7 dwell cycle
// Revision    : 1.0 - initial release
// ============================================================================
module cube_layer_scheduler #(
    parameter int DWELL_CYCLES = 6250,  // cycles a layer is lit
    parameter int BLANK_CYCLES = 50     // dark cycles between layers (>= 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        swap_req,
    input  logic [3:0]  brightness,
    output logic        swap_ack,
    output logic [7:0]  layer_en,
    output logic [63:0] col_data,
    output logic        frame_tick
);

    localparam int c_MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t               r_state, w_state_n;
    logic [2:0]           r_layer, w_layer_n;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_n;
    logic                 w_load_cols;
    logic                 w_frame_end;
    logic                 w_swap;
    logic                 w_pwm_on;
    logic                 r_pending;
    logic                 r_front;
    logic [63:0]          r_col;

    // Both banks in one array; the top address bit selects the bank.
    logic [7:0]           r_mem [0:127];

    // ------------------------------------------------------------------
    // Scanner FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_layer <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_layer <= w_layer_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_layer_n   = r_layer;
        w_cnt_n     = r_cnt;
        w_load_cols = 1'b0;
        // Frame end is a property of the dwell itself, so a swap still
        // lands even if enable drops in that very cycle.
        w_frame_end = (r_state == SHOW) && (r_layer == 3'd7) && (r_cnt == c_DWELL_LAST);
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_n = BLANK;
                    w_layer_n = 3'd0;
                    w_cnt_n   = '0;
                end
            end
            BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_state_n   = SHOW;
                    w_cnt_n     = '0;
                    w_load_cols = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            SHOW: begin
                if (r_cnt == c_DWELL_LAST) begin
                    w_state_n = BLANK;
                    w_cnt_n   = '0;
                    w_layer_n = r_layer + 3'd1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
        if (!enable) begin
            w_state_n   = IDLE;
            w_cnt_n     = '0;
            w_load_cols = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Swap handshake: a request in the swap cycle is absorbed by it.
    // ------------------------------------------------------------------
    assign w_swap = r_pending & ((r_state == IDLE) | w_frame_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_front   <= 1'b0;
        end else if (w_swap) begin
            r_pending <= 1'b0;
            r_front   <= ~r_front;
        end else if (swap_req) begin
            r_pending <= 1'b1;
        end
    end

    // Writes always target the bank that is back before this edge, so a
    // write in the swap cycle ends up in the newly presented bank.
    // Contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[{~r_front, wr_addr}] <= wr_data;
        end
    end

    // Column latch: captured once at dwell entry, cleared whenever idle.
    always_ff @(posedge clk) begin
        if (reset || (w_state_n == IDLE)) begin
            r_col <= '0;
        end else if (w_load_cols) begin
            for (int r = 0; r < 8; r++) begin
                r_col[8*r +: 8] <= r_mem[{r_front, r_layer, 3'(r)}];
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional global dimming
    // ------------------------------------------------------------------
`ifdef CUBE_PWM_EN
    logic [3:0] r_pwm_cnt;
    logic [3:0] r_bright;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= 4'd0;
            r_bright  <= 4'd0;
        end else if (w_load_cols) begin
            r_pwm_cnt <= 4'd0;
            r_bright  <= brightness;
        end else if (r_state == SHOW) begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign w_pwm_on = (r_pwm_cnt < r_bright);
`else
    // Brightness has no effect in this build; the layer is lit all dwell.
    assign w_pwm_on = 1'b1 | (^brightness);
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign layer_en   = ((r_state == SHOW) && w_pwm_on) ? (8'd1 << r_layer) : 8'd0;
    assign col_data   = r_col;
    assign swap_ack   = w_swap & ~reset;
    assign frame_tick = w_frame_end & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_cube_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cube_layer_scheduler
// Description : Self-checking bench for cube_layer_scheduler with
//               DWELL_CYCLES=8, BLANK_CYCLES=2. A timeline model (position
//               since scan start, banks as arrays) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cube_layer_scheduler;

    localparam int DW    = 8;
    localparam int BL    = 2;
    localparam int SLOT  = DW + BL;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        reset, enable, wr_en, swap_req;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  brightness;
    logic        swap_ack, frame_tick;
    logic [7:0]  layer_en;
    logic [63:0] col_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cube_layer_scheduler #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .swap_req(swap_req),
        .brightness(brightness), .swap_ack(swap_ack), .layer_en(layer_en),
        .col_data(col_data), .frame_tick(frame_tick)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_bank [2][64];
    bit         m_idle  = 1'b1;
    bit         m_pend  = 1'b0;
    bit         m_front = 1'b0;
    int         m_pos   = 0;
    int         m_bright = 0;

    function automatic bit m_show();
        return !m_idle && (m_pos % SLOT >= BL);
    endfunction

    function automatic bit exp_tick();
        return !m_idle && (m_pos % FRAME == FRAME - 1);
    endfunction

    function automatic bit exp_ack();
        return m_pend && (m_idle || exp_tick());
    endfunction

    function automatic logic [7:0] exp_layer_en();
        if (!m_show()) return 8'h00;
`ifdef CUBE_PWM_EN
        if ((m_pos % SLOT - BL) >= m_bright) return 8'h00;
`endif
        return 8'(1) << ((m_pos / SLOT) % 8);
    endfunction

    function automatic logic [63:0] exp_col();
        logic [63:0] v;
        v = '0;
        if (!m_idle)
            for (int r = 0; r < 8; r++)
                v[8*r +: 8] = m_bank[m_front][((m_pos / SLOT) % 8) * 8 + r];
        return v;
    endfunction

    // Drive one cycle of inputs, apply the edge to the model, return at negedge.
    task automatic tick(input bit rst, input bit en, input bit we,
                        input logic [5:0] wa, input logic [7:0] wd, input bit sr);
        bit sw;
        reset = rst; enable = en; wr_en = we; wr_addr = wa; wr_data = wd; swap_req = sr;
        @(posedge clk);
        if (rst) begin
            m_idle = 1'b1; m_pend = 1'b0; m_front = 1'b0; m_pos = 0;
        end else begin
            sw = m_pend && (m_idle || (m_pos % FRAME == FRAME - 1));
            if (we) m_bank[!m_front][wa] = wd;
            if (sw) begin m_front = !m_front; m_pend = 1'b0; end
            else if (sr) m_pend = 1'b1;
            if (!en) m_idle = 1'b1;
            else if (m_idle) begin m_idle = 1'b0; m_pos = 0; end
            else m_pos++;
            if (!m_idle && (m_pos % SLOT == BL)) m_bright = int'(brightness);
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        total++; if (layer_en !== 8'h00) begin bad++; $display("FAIL reset_layer_en got=%h exp=00", layer_en); end
        total++; if (col_data !== 64'h0) begin bad++; $display("FAIL reset_col got=%h exp=0", col_data); end
        total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", swap_ack); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        tick(0, 0, 0, 0, 0, 0);
    endtask

    // Fill both banks so the model knows every byte; exercises the idle swap.
    task automatic test_fill();
        for (int a = 0; a < 64; a++) tick(0, 0, 1, 6'(a), 8'($urandom), 0);
        tick(0, 0, 0, 0, 0, 1);
        total++; if (swap_ack !== 1'b1) begin bad++; $display("FAIL idle_swap_ack got=%b exp=1", swap_ack); end
        tick(0, 0, 0, 0, 0, 0);
        total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL idle_swap_once got=%b exp=0", swap_ack); end
        for (int a = 0; a < 64; a++) tick(0, 0, 1, 6'(a), 8'($urandom), 0);
    endtask

    task automatic test_scan_timing();
        logic [7:0] e;
        for (int k = 1; k <= 13; k++) begin
            tick(0, 1, 0, 0, 0, 0);
            e = (k >= 3 && k <= 10) ? 8'h01 : (k == 13) ? 8'h02 : 8'h00;
            total++; if (layer_en !== e) begin bad++; $display("FAIL scan_edge%0d got=%h exp=%h", k, layer_en, e); end
            if (e != 8'h00) begin
                total++; if (col_data !== exp_col()) begin bad++; $display("FAIL scan_col%0d got=%h exp=%h", k, col_data, exp_col()); end
            end
        end
        tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_swap();
        int  acks = 0;
        bit  seen = 0;
        tick(0, 0, 1, 6'd0, 8'hA5, 0);
        tick(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            if (swap_ack === 1'b1) begin
                acks++; seen = 1;
                total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL swap_ack_tick got=%b exp=1", frame_tick); end
            end else if (seen && layer_en === 8'h01) begin
                total++; if (col_data[7:0] !== 8'hA5) begin bad++; $display("FAIL swap_col0 got=%h exp=a5", col_data[7:0]); end
            end
        end
        total++; if (acks != 1) begin bad++; $display("FAIL swap_ack_count got=%0d exp=1", acks); end
        tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_multi_swap();
        int acks = 0;
        int p0, p1, p2;
        p0 = 5 + $urandom_range(0, 19);
        p1 = 30 + $urandom_range(0, 19);
        p2 = 55 + $urandom_range(0, 19);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(0, 1, 0, 0, 0, (i == p0 || i == p1 || i == p2));
            if (swap_ack === 1'b1) begin
                acks++;
                total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL multi_ack_tick got=%b exp=1", frame_tick); end
            end
        end
        total++; if (acks != 1) begin bad++; $display("FAIL multi_ack_count got=%0d exp=1", acks); end
        tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_disable();
        tick(0, 1, 0, 0, 0, 0);
        while (m_pos != 4 * SLOT + BL + 3) tick(0, 1, 0, 0, 0, 0);
        total++; if (layer_en !== 8'h10) begin bad++; $display("FAIL dis_layer4 got=%h exp=10", layer_en); end
        tick(0, 0, 0, 0, 0, 0);
        total++; if (layer_en !== 8'h00) begin bad++; $display("FAIL dis_layer_en got=%h exp=00", layer_en); end
        total++; if (col_data !== 64'h0) begin bad++; $display("FAIL dis_col got=%h exp=0", col_data); end
        tick(0, 1, 0, 0, 0, 0);
        total++; if (layer_en !== 8'h00) begin bad++; $display("FAIL reen_blank0 got=%h exp=00", layer_en); end
        tick(0, 1, 0, 0, 0, 0);
        total++; if (layer_en !== 8'h00) begin bad++; $display("FAIL reen_blank1 got=%h exp=00", layer_en); end
        tick(0, 1, 0, 0, 0, 0);
        total++; if (layer_en !== 8'h01) begin bad++; $display("FAIL reen_layer0 got=%h exp=01", layer_en); end
    endtask

    // Runs with the scan still enabled from test_disable.
    task automatic test_swap_cycle_write();
        logic [7:0] v;
        int n;
        v = 8'($urandom);
        tick(0, 1, 0, 0, 0, 1);
        n = 0;
        while (swap_ack !== 1'b1 && n < 2 * FRAME) begin tick(0, 1, 0, 0, 0, 0); n++; end
        total++; if (swap_ack !== 1'b1) begin bad++; $display("FAIL swcyc_ack_timeout got=%b exp=1", swap_ack); end
        tick(0, 1, 1, 6'd9, v, 0);
        n = 0;
        while (layer_en !== 8'h02 && n < 3 * SLOT) begin tick(0, 1, 0, 0, 0, 0); n++; end
        total++; if (col_data[15:8] !== v) begin bad++; $display("FAIL swcyc_col1 got=%h exp=%h", col_data[15:8], v); end
        tick(0, 0, 0, 0, 0, 0);
    endtask

`ifdef CUBE_PWM_EN
    task automatic test_pwm();
        int hi;
        brightness = 4'd4;
        tick(0, 1, 0, 0, 0, 0);
        hi = 0;
        for (int i = 0; i < SLOT; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            if (layer_en !== 8'h00) hi++;
            total++; if (layer_en !== exp_layer_en()) begin bad++; $display("FAIL pwm4_cyc%0d got=%h exp=%h", i, layer_en, exp_layer_en()); end
        end
        total++; if (hi != 4) begin bad++; $display("FAIL pwm4_count got=%0d exp=4", hi); end
        tick(0, 0, 0, 0, 0, 0);
        brightness = 4'd0;
        tick(0, 1, 0, 0, 0, 0);
        hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            if (layer_en !== 8'h00) hi++;
        end
        total++; if (hi != 0) begin bad++; $display("FAIL pwm0_count got=%0d exp=0", hi); end
        tick(0, 0, 0, 0, 0, 0);
        brightness = 4'd15;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3 * FRAME + 60; i++) begin
            brightness = 4'($urandom);
            tick(0, ($urandom % 150) != 0, $urandom_range(0, 1), 6'($urandom), 8'($urandom),
                 ($urandom % 25) == 0);
            total++; if (layer_en !== exp_layer_en()) begin bad++; $display("FAIL rnd_layer_en i=%0d got=%h exp=%h", i, layer_en, exp_layer_en()); end
            total++; if (frame_tick !== exp_tick()) begin bad++; $display("FAIL rnd_tick i=%0d got=%b exp=%b", i, frame_tick, exp_tick()); end
            total++; if (swap_ack !== exp_ack()) begin bad++; $display("FAIL rnd_ack i=%0d got=%b exp=%b", i, swap_ack, exp_ack()); end
            if (m_idle || m_show()) begin
                total++; if (col_data !== exp_col()) begin bad++; $display("FAIL rnd_col i=%0d got=%h exp=%h", i, col_data, exp_col()); end
            end
        end
        brightness = 4'd15;
        tick(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        swap_req = 1'b0; brightness = 4'd15;
        @(negedge clk);
        test_reset();
        test_fill();
        test_scan_timing();
        test_swap();
        test_multi_swap();
        test_disable();
        test_swap_cycle_write();
`ifdef CUBE_PWM_EN
        test_pwm();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cube_layer_scheduler.md
CUBE_LAYER_SCHEDULER -- requirements
Module: cube_layer_scheduler

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 6250, giving the clk cycles each layer is lit (1 kHz frame at 50 MHz, 8 layers).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 50, giving the clk cycles all layers are dark between layers (anti-ghosting).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit, which runs the scan when high.
REQ-006 The block SHALL have port wr_en, input, 1 bit, a back-buffer byte write strobe.
REQ-007 The block SHALL have port wr_addr, input, 6 bits, where the address is layer*8+row.
REQ-008 The block SHALL have port wr_data, input, 8 bits, where bit i is the LED at column i.
REQ-009 The block SHALL have port swap_req, input, 1 bit, a request to present the back buffer.
REQ-010 The block SHALL have port brightness, input, 4 bits, the global duty (used only under CUBE_PWM_EN).
REQ-011 The block SHALL have port swap_ack, output, 1 bit, a 1-cycle pulse when a swap takes effect.
REQ-012 The block SHALL have port layer_en, output, 8 bits, a one-hot layer drive that is all-zero when dark.
REQ-013 The block SHALL have port col_data, output, 64 bits, where bits [8r+7:8r] are row r of the lit layer.
REQ-014 The block SHALL have port frame_tick, output, 1 bit, a 1-cycle pulse at the end of the layer-7 dwell.

Function
REQ-015 The block SHALL keep two 64x8 banks, front (scanned) and back (written), and SHALL never write the front bank.
REQ-016 The block SHALL store wr_data at back[wr_addr] on every cycle that wr_en is high, with no busy or back-pressure condition.
REQ-017 A write in the same cycle as a swap SHALL land in the pre-swap back bank, which then becomes the front bank.
REQ-018 The scanner FSM SHALL have exactly the states IDLE, BLANK, SHOW and SHALL keep a 3-bit layer index.
REQ-019 In IDLE, if enable is high, the FSM SHALL set layer to 0 and move to BLANK.
REQ-020 BLANK SHALL last exactly BLANK_CYCLES cycles with layer_en=0, then the FSM SHALL move to SHOW.
REQ-021 On SHOW entry, col_data SHALL be registered from front[layer*8+0..7] and held constant for the whole dwell.
REQ-022 SHOW SHALL last exactly DWELL_CYCLES cycles with layer_en=1<<layer, then the FSM SHALL increment layer (7 wraps to 0) and move to BLANK.
REQ-023 Latency SHALL be fixed: enable rising at edge t gives layer_en[0] high from edge t+1+BLANK_CYCLES.
REQ-024 A swap_req pulse SHALL set a sticky pending flag, and repeated requests while pending SHALL merge into one.
REQ-025 When pending is set, the bank swap SHALL occur on the cycle SHOW for layer 7 ends (the same cycle as frame_tick), or on the next cycle if in IDLE; swap_ack SHALL pulse in that swap cycle and pending SHALL clear.
REQ-026 A swap_req in the swap cycle itself SHALL be absorbed by that swap and SHALL NOT leave pending set.
REQ-027 Deasserting enable in any state SHALL return the FSM to IDLE on the next edge, with layer_en=0 and col_data=0 from that edge on.
REQ-028 Only one bit of layer_en SHALL ever be high, and layer_en SHALL be 0 in IDLE and BLANK.

Reset
REQ-029 While reset is high, the block SHALL set FSM=IDLE, layer=0, counters=0, pending=0, front=bank 0, layer_en=0, col_data=0, swap_ack=0 and frame_tick=0.
REQ-030 Bank contents SHALL NOT be cleared by reset.
REQ-031 A reset in mid-dwell SHALL force layer_en to 0 on the reset edge and SHALL drop any pending swap.

Configuration
REQ-032 With macro CUBE_PWM_EN defined, a 4-bit counter SHALL free-run during SHOW, brightness SHALL be sampled at SHOW entry, and layer_en SHALL be gated to 0 while the counter is >= that value (0 = dark, 15 = 15/16 duty).
REQ-033 With CUBE_PWM_EN undefined, brightness SHALL be ignored and layer_en SHALL be high for the full dwell.

Verification (DWELL_CYCLES=8, BLANK_CYCLES=2)
REQ-034 Bench SHALL cover: reset, enable=1 at edge 0 -> layer_en=0x01 at edges 3..10, 0x00 at 11..12, 0x02 at 13.
REQ-035 Bench SHALL cover: write 0xA5 at addr 0, swap_req, enable -> one swap_ack at the first frame end, then col_data[7:0]=0xA5 whenever layer_en=0x01.
REQ-036 Bench SHALL cover: swap_req 3 times within one frame -> exactly one swap_ack, coincident with frame_tick.
REQ-037 Bench SHALL cover: enable dropped in layer-4 SHOW -> layer_en=0 and col_data=0 next edge; re-enable -> restart at layer 0 after 2 blank cycles.
REQ-038 Bench SHALL cover: wr_en to addr 9 in the swap cycle -> the written value is visible on col_data[15:8] during layer 1 of the next frame.
REQ-039 Bench SHALL cover, under CUBE_PWM_EN: brightness=4 -> layer_en high for 4 cycles, low for 4 per dwell; brightness=0 -> never high.
